uart_rx_aux: RTL and testbench
==============================

# uart_rx_aux

Auxiliary-UART serial receiver, the consumer end of the 16x oversampling baud-tick generator. It deserialises an 8N1 (default) asynchronous frame from the `rx` line. It samples each bit at its midpoint using the tick strobe, and presents the received word with a one-cycle `rx_done` strobe plus a framing-error flag. It sits between the board RX pin and the debug/loader FSM that feeds the MIPS pipeline.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `NUM_TICKS`, 16: ticks per bit period. Must match the generator's oversampling factor.
- `STOP_TICKS`, 16: ticks spent in the stop bit before sampling it. 16 means one stop bit.
- `clock` in 1: system clock, 100 MHz nominal.
- `reset` in 1: synchronous, active-high; clock clock.
- `tick` in 1: one-clock strobe at `NUM_TICKS` x baud, from the baud generator.
- `rx` in 1: asynchronous serial input. Idles high.
- `rx_done` out 1: one-clock pulse when a frame completes.
- `data_out` out `DATA_BITS`: last received word. Held until the next `rx_done`.
- `framing_error` out 1: set when the sampled stop bit was 0. Valid with `rx_done` and held until the next `rx_done`.
- `parity_error` out 1: parity mismatch. Valid with `rx_done`. Constant 0 unless parity is enabled (see Configuration).

## Operation
- `rx` passes through a 2-flop synchroniser; `rx_s` is its output. Both flops reset to 1.
- Internal registers:
  - Tick counter `s`: width `$clog2(max(NUM_TICKS,STOP_TICKS))`.
  - Bit counter `n`: width `$clog2(DATA_BITS)`.
  - Shift register `b`: width `DATA_BITS`.
- States:
  - **IDLE**: on any clock with `rx_s==0`: clear `s`, go to START. `tick` is not required.
  - **START**: on `tick`:
    - `s==NUM_TICKS/2-1` and `rx_s==0`: clear `s` and `n`, go to DATA.
    - `s==NUM_TICKS/2-1` and `rx_s==1`: glitch; go to IDLE with no outputs changed.
    - Otherwise increment `s`.
  - **DATA**: on `tick`:
    - `s==NUM_TICKS-1`: shift right with `b <= {rx_s, b[DATA_BITS-1:1]}`, clear `s`.
    - If that was the last bit (`n==DATA_BITS-1`), go to STOP (or PARITY). Otherwise increment `n`.
    - Other ticks increment `s`.
  - **PARITY** (only with the macro): on `tick` with `s==NUM_TICKS-1`: latch the parity bit, clear `s`, go to STOP.
  - **STOP**: on `tick` with `s==STOP_TICKS-1`, in one clock:
    - `data_out<=b`, `framing_error<=~rx_s`, `rx_done<=1`.
    - Go to IDLE.
- `rx_done` is registered and drops the following clock.
- A frame with a bad stop bit still raises `rx_done` and updates `data_out`. Discarding it is the consumer's job.
- A frame with a bad stop bit returns to IDLE. If `rx_s` is still low, the next clock re-enters START.
- Counters never wrap: `s` is always cleared at its terminal value, and `n` at the STOP transition.
- Clocks without `tick` leave all state unchanged, except the IDLE start detect.

## Timing
- Reset values: `rx_done=0`, `data_out=0`, `framing_error=0`, `parity_error=0`, state IDLE, `s`, `n` and `b` all 0.
- Start detect: 2 clocks of synchroniser latency, plus 1 clock to enter START.
- Sample points:
  - Start bit: `NUM_TICKS/2` ticks after detect.
  - Each data/parity bit: `NUM_TICKS` ticks after the previous sample.
  - Stop bit: `STOP_TICKS` ticks after the last data/parity bit.
- `rx_done` asserts the clock after the stop-sampling tick. Total latency from the start-bit edge is ≈(`NUM_TICKS/2` + `DATA_BITS`·`NUM_TICKS` + `STOP_TICKS`) ticks + 3 clocks.
- Back-to-back frames: a start edge that follows immediately after the stop sample is detected. No dead time is required beyond the one IDLE clock.
- `reset` asserted mid-frame: next clock is IDLE and all outputs are 0. No `rx_done` is produced for the aborted frame.
- `reset` has priority over `tick` in the same cycle.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is compiled in; frame is start + `DATA_BITS` + even-parity bit + stop.
  - `parity_error <= (^b) ^ parity_bit` on the `rx_done` cycle.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - `parity_error` is tied to 0.
  - Frame is 8N1.

## Test plan
- **Nominal byte**: drive 0xA5 at 9600 baud with tick every 651 clocks and stop=1 → exactly one `rx_done` pulse, `data_out=0xA5`, `framing_error=0`.
- **Glitch**: `rx` low for 4 tick periods, then high → FSM returns to IDLE, no `rx_done`, `data_out` unchanged.
- **Framing**: drive 0x3C with stop bit 0 → `rx_done=1`, `data_out=0x3C`, `framing_error=1`. A following valid 0x55 → `framing_error=0`.
- **Back-to-back**: drive 0x00 then immediately 0xFF → two `rx_done` pulses 10 bit periods apart, with `data_out` 0x00 then 0xFF.
- **Reset mid-frame**: assert `reset` for 1 clock during data bit 4 of 0x81 → outputs 0, no `rx_done`. The next frame 0x7E is received correctly.
- **Parity** (`UART_RX_PARITY_EN`): 0x07 with parity 1 → `parity_error=0`. 0x07 with parity 0 → `parity_error=1`, `rx_done=1`.

Source files
------------

// File: rtl/uart_rx_aux.sv
// Auxiliary-UART 16x-oversampled serial receiver (8N1 by default).
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_aux #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned NUM_TICKS  = 16,
   parameter int unsigned STOP_TICKS = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 i_tick,
   input  logic                 i_rx,
   output logic                 o_rx_done,
   output logic [DATA_BITS-1:0] o_data_out,
   output logic                 o_framing_error,
   output logic                 o_parity_error
);

   localparam int unsigned MaxTicks = (NUM_TICKS > STOP_TICKS) ? NUM_TICKS : STOP_TICKS;
   localparam int unsigned SW       = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
   localparam int unsigned NW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [SW-1:0] SHalf = SW'(NUM_TICKS / 2 - 1);
   localparam logic [SW-1:0] SBit  = SW'(NUM_TICKS - 1);
   localparam logic [SW-1:0] SStop = SW'(STOP_TICKS - 1);
   localparam logic [NW-1:0] NLast = NW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
   typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

   state_e               r_state;
   logic [1:0]           r_sync;
   logic [SW-1:0]        r_s;
   logic [NW-1:0]        r_n;
   logic [DATA_BITS-1:0] r_b;
   logic                 r_rx_done;
   logic [DATA_BITS-1:0] r_data_out;
   logic                 r_framing_error;
   logic                 w_rx_s;

   assign w_rx_s = r_sync[1];

`ifdef UART_RX_PARITY_EN
   logic r_parity_bit;
   logic r_parity_error;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_parity_bit   <= 1'b0;
         r_parity_error <= 1'b0;
      end else if (i_tick) begin
         if (r_state == StParity && r_s == SBit) begin
            r_parity_bit <= w_rx_s;
         end
         if (r_state == StStop && r_s == SStop) begin
            // even parity: data XOR parity bit must be 0
            r_parity_error <= (^r_b) ^ r_parity_bit;
         end
      end
   end

   assign o_parity_error = r_parity_error;
`else
   assign o_parity_error = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync          <= 2'b11;
         r_state         <= StIdle;
         r_s             <= '0;
         r_n             <= '0;
         r_b             <= '0;
         r_rx_done       <= 1'b0;
         r_data_out      <= '0;
         r_framing_error <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], i_rx};
         r_rx_done <= 1'b0;
         case (r_state)
            StIdle: begin
               // start detect runs every clock, not only on ticks
               if (!w_rx_s) begin
                  r_s     <= '0;
                  r_state <= StStart;
               end
            end
            StStart: begin
               if (i_tick) begin
                  if (r_s == SHalf) begin
                     if (!w_rx_s) begin
                        r_s     <= '0;
                        r_n     <= '0;
                        r_state <= StData;
                     end else begin
                        r_state <= StIdle;
                     end
                  end else begin
                     r_s <= r_s + 1'b1;
                  end
               end
            end
            StData: begin
               if (i_tick) begin
                  if (r_s == SBit) begin
                     r_b <= {w_rx_s, r_b[DATA_BITS-1:1]};
                     r_s <= '0;
                     if (r_n == NLast) begin
                        r_n     <= '0;
`ifdef UART_RX_PARITY_EN
                        r_state <= StParity;
`else
                        r_state <= StStop;
`endif
                     end else begin
                        r_n <= r_n + 1'b1;
                     end
                  end else begin
                     r_s <= r_s + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (i_tick) begin
                  if (r_s == SBit) begin
                     r_s     <= '0;
                     r_state <= StStop;
                  end else begin
                     r_s <= r_s + 1'b1;
                  end
               end
            end
`endif
            StStop: begin
               if (i_tick) begin
                  if (r_s == SStop) begin
                     r_s             <= '0;
                     r_data_out      <= r_b;
                     r_framing_error <= ~w_rx_s;
                     r_rx_done       <= 1'b1;
                     r_state         <= StIdle;
                  end else begin
                     r_s <= r_s + 1'b1;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_rx_done       = r_rx_done;
   assign o_data_out      = r_data_out;
   assign o_framing_error = r_framing_error;

endmodule

// File: tb/tb_uart_rx_aux.sv
// Scoreboard bench for uart_rx_aux: driver queues expected frames, monitor checks each rx_done.
module tb_uart_rx_aux;

   localparam int TICK_DIV = 4;
   localparam int BIT_CLKS = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       tick  = 1'b0;
   logic       rx    = 1'b1;
   logic       rx_done;
   logic [7:0] data_out;
   logic       framing_error;
   logic       parity_error;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   exp_t exp_q[$];
   int   done_cyc[$];
   int   cyc        = 0;
   int   errors     = 0;
   int   checks     = 0;
   int   n_expected = 0;

   uart_rx_aux #(
      .DATA_BITS (8),
      .NUM_TICKS (16),
      .STOP_TICKS(16)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .i_tick         (tick),
      .i_rx           (rx),
      .o_rx_done      (rx_done),
      .o_data_out     (data_out),
      .o_framing_error(framing_error),
      .o_parity_error (parity_error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      int tcnt;
      tcnt = 0;
      forever begin
         @(posedge clock);
         #1;
         tick = (tcnt == TICK_DIV - 1);
         tcnt = (tcnt + 1) % TICK_DIV;
      end
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every rx_done pops one expected frame.
   always @(negedge clock) begin
      if (rx_done === 1'b1) begin
         exp_t e;
         done_cyc.push_back(cyc);
         check("rx_done_expected", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("data_out", int'(data_out), int'(e.d));
            check("framing_error", int'(framing_error), int'(e.fe));
            check("parity_error", int'(parity_error), int'(e.pe));
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic fe, input logic par);
      exp_t e;
      e.d  = d;
      e.fe = fe;
`ifdef UART_RX_PARITY_EN
      e.pe = (^d) ^ par;
`else
      e.pe = 1'b0 & par;
`endif
      exp_q.push_back(e);
      n_expected++;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par);
      rx = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_clks(BIT_CLKS);
      end
`ifdef UART_RX_PARITY_EN
      rx = par;
      wait_clks(BIT_CLKS);
`endif
      if (stop_ok) begin
         rx = 1'b1;
         wait_clks(BIT_CLKS);
      end else begin
         // short low stop: past the sample point, too short to pass as a new start bit
         rx = 1'b0;
         wait_clks(40);
         rx = 1'b1;
         wait_clks(2 * BIT_CLKS);
      end
   endtask

   task automatic good_frame(input logic [7:0] d);
      expect_frame(d, 1'b0, ^d);
      send_frame(d, 1'b1, ^d);
   endtask

   initial begin
      int k;
      logic [7:0] d81;
      d81 = 8'h81;

      wait_clks(3);
      reset = 1'b0;
      @(negedge clock);
      check("reset_rx_done", int'(rx_done), 0);
      check("reset_data_out", int'(data_out), 0);
      check("reset_framing_error", int'(framing_error), 0);
      check("reset_parity_error", int'(parity_error), 0);
      wait_clks(2 * BIT_CLKS);

      good_frame(8'hA5);
      wait_clks(2 * BIT_CLKS);

      rx = 1'b0;
      wait_clks(4 * TICK_DIV);
      rx = 1'b1;
      wait_clks(3 * BIT_CLKS);
      check("glitch_data_held", int'(data_out), 'hA5);
      check("glitch_done_count", done_cyc.size(), 1);

      expect_frame(8'h3C, 1'b1, ^8'h3C);
      send_frame(8'h3C, 1'b0, ^8'h3C);
      good_frame(8'h55);
      wait_clks(2 * BIT_CLKS);

      k = done_cyc.size();
      good_frame(8'h00);
      good_frame(8'hFF);
      wait_clks(2 * BIT_CLKS);
      check("b2b_done_count", done_cyc.size(), k + 2);
      if (done_cyc.size() >= k + 2) begin
         check("b2b_spacing", done_cyc[k+1] - done_cyc[k], FRAME_BITS * BIT_CLKS);
      end

      rx = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         rx = d81[i];
         wait_clks(BIT_CLKS);
      end
      rx = d81[4];
      wait_clks(BIT_CLKS / 2);
      rx    = 1'b1;
      reset = 1'b1;
      wait_clks(1);
      reset = 1'b0;
      @(negedge clock);
      check("midreset_rx_done", int'(rx_done), 0);
      check("midreset_data_out", int'(data_out), 0);
      check("midreset_framing_error", int'(framing_error), 0);
      check("midreset_parity_error", int'(parity_error), 0);
      wait_clks(3 * BIT_CLKS);
      good_frame(8'h7E);
      wait_clks(2 * BIT_CLKS);

`ifdef UART_RX_PARITY_EN
      expect_frame(8'h07, 1'b0, 1'b1);
      send_frame(8'h07, 1'b1, 1'b1);
      wait_clks(2 * BIT_CLKS);
      expect_frame(8'h07, 1'b0, 1'b0);
      send_frame(8'h07, 1'b1, 1'b0);
      wait_clks(2 * BIT_CLKS);
`endif

      check("pending_expected", exp_q.size(), 0);
      check("total_done_count", done_cyc.size(), n_expected);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
